keyboard_event_fifo: RTL
========================

# keyboard_event_fifo

Sits directly downstream of the PS/2 byte receiver and consumes its `scancode`/`ready` outputs. It brings `ready` into the `CLOCK_50` domain and parses Set-2 prefix sequences (E0, F0, E1) into complete key events. It tracks Shift and Caps Lock, translates each event to ASCII, and queues events in a show-ahead FIFO read by the CPU keyboard port.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: event entries; power of two, ≥2.

Ports:
- `CLOCK_50`  in  1  system clock.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `scancode`  in  8  byte from the PS/2 receiver. Stable for ≥20 µs after `scancode_ready` rises.
- `scancode_ready`  in  1  byte-complete strobe from the PS2_CLK domain; asynchronous to `CLOCK_50`.
- `key_valid`  out  1  FIFO non-empty; head fields are valid.
- `key_rd`  in  1  pop head this cycle; ignored when `key_valid`=0.
- `key_code`  out  8  head: final Set-2 code byte, without prefixes.
- `key_ascii`  out  8  head: translated ASCII; 0x00 if no mapping.
- `key_release`  out  1  head: break event (F0 seen).
- `key_extended`  out  1  head: E0 prefix seen.
- `key_count`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `overflow`  out  1  sticky; set when an event is dropped.
- `overflow_clr`  in  1  clears `overflow`. Loses to a same-cycle set.
- `shift_state`  out  1  either Shift currently held.
- `caps_lock`  out  1  Caps Lock toggle state.

## Operation
- Sync: 2-flop synchronizer on `scancode_ready`, followed by a registered rising-edge detect. One byte strobe per rising edge. `scancode` is sampled on the strobe.
- Parser states:
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - E1 → PAUSE, skip counter = 7.
    - Any other byte → emit event {ext=0, rel=0}.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → stay in EXT.
    - Any other byte → emit {ext=1, rel=0}, go to IDLE.
  - BRK: any byte → emit {ext=0, rel=1}, go to IDLE.
  - EXT_BRK: any byte → emit {ext=1, rel=1}, go to IDLE.
  - PAUSE: discard each byte and decrement the counter; go to IDLE after the counter reaches 0. No event is produced.
- Modifiers:
  - Non-extended 0x12 (L-Shift) and 0x59 (R-Shift): make sets, break clears their own bit. `shift_state` = OR of the two bits.
  - Non-extended 0x58 make toggles `caps_lock`; break does nothing.
  - Modifier events are still queued.
- ASCII: combinational from the code, using the modifier state *before* this event's update. Applies to both make and break.
  - Letters: lowercase, uppercase when shift XOR caps.
  - Digits and punctuation: US layout, shifted symbol when shift.
  - 0x29 → 0x20.
  - 0x5A → 0x0D.
  - 0x66 → 0x08.
  - 0x0D → 0x09.
  - 0x76 → 0x1B.
  - Every extended code → 0x00.
  - Every unlisted code → 0x00.
- FIFO behaviour:
  - Show-ahead; entry is {ext, rel, code, ascii}.
  - Push when full without a same-cycle pop: event dropped, `overflow` set, contents unchanged.
  - Push and pop in the same cycle: both take effect, count unchanged. Applies when full too, where the new event is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Bytes 0x00 and 0xAA (BAT) in IDLE are discarded with no event. 0xFA and 0xEE are discarded likewise.

## Timing
- Reset (asynchronous, any state, mid-sequence included) returns all outputs and state to:
  - synchronizer and edge flops 0, parser IDLE, skip counter 0;
  - FIFO empty, `key_count`=0, `key_valid`=0;
  - `key_code`=`key_ascii`=0x00, `key_release`=`key_extended`=0;
  - `overflow`=0, `shift_state`=0, `caps_lock`=0.
- Latency:
  - N = first `CLOCK_50` edge sampling `scancode_ready`=1.
  - Strobe is registered at N+2; `scancode` is sampled there.
  - Event is written at N+3; `key_valid` is high after N+3.
  - Modifier state updates at N+3.
- `key_rd` with `key_valid`=1: the next head is visible the following cycle. `key_count` decrements unless a same-cycle push occurs.
- `scancode_ready` held high produces one strobe only. Glitches shorter than one clock may be missed; this is acceptable.

## Test plan
- Byte 0x1C → one entry {code 0x1C, ascii 0x61, rel 0, ext 0}. `key_valid` rises after edge N+3; `key_rd` → `key_valid`=0.
- Sequence 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12 → 4 entries:
  - {0x12, 0x00};
  - {0x1C, 0x41};
  - {0x1C, 0x41, rel};
  - {0x12, rel}.
  - `shift_state` ends at 0.
- Sequence E0 F0 75 → {code 0x75, ext 1, rel 1, ascii 0x00}. Next 0x75 → ext 0, producing ascii 0x00 from keypad 8 (unmapped).
- 0x58 make, then 0x1C → ascii 0x41, `caps_lock`=1. Then 0x12 make, 0x1C → ascii 0x61.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → no entries. A following 0x29 → ascii 0x20.
- Fill 8 entries, push a 9th → `overflow`=1, count 8, head unchanged. Push with a simultaneous `key_rd` → count stays 8. Then `overflow_clr` → 0. Assert `RESET_N`=0 mid-E0 → empty and parser IDLE.

Source files
------------

// File: rtl/keyboard_event_fifo.sv
// PS/2 Set-2 scancode parser with Shift/Caps tracking, ASCII translation and
// a show-ahead key-event FIFO feeding the CPU keyboard port.
package keyboard_event_fifo_pkg;
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
        logic [7:0] ascii;
    } key_event_t;
endpackage

module keyboard_event_fifo
    import keyboard_event_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET_N,
    input  logic [7:0]                  scancode,
    input  logic                        scancode_ready,
    output logic                        key_valid,
    input  logic                        key_rd,
    output logic [7:0]                  key_code,
    output logic [7:0]                  key_ascii,
    output logic                        key_release,
    output logic                        key_extended,
    output logic [$clog2(FIFO_DEPTH):0] key_count,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic                        shift_state,
    output logic                        caps_lock
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

    logic             r_sync1, r_sync2, r_sync3, r_strobe;
    logic [7:0]       r_byte;
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_skip, w_skip_nxt;
    logic             w_emit, w_ext, w_rel;
    logic             r_lshift, r_rshift, r_shift, r_caps;
    logic             w_lshift_nxt, w_rshift_nxt, w_caps_nxt;
    logic [7:0]       w_base, w_shifted, w_ascii;
    logic             w_letter;
    key_event_t       w_event, r_head, w_head_nxt;
    key_event_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_valid, r_overflow;
    logic             w_full, w_pop, w_push_ok, w_ovf_set;

    // Two-flop synchronizer plus registered rising-edge strobe; byte captured with it
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync3  <= 1'b0;
            r_strobe <= 1'b0;
            r_byte   <= 8'h00;
        end else begin
            r_sync1  <= scancode_ready;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_strobe <= r_sync2 & ~r_sync3;
            if (r_sync2 & ~r_sync3)
                r_byte <= scancode;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_emit      = 1'b0;
        w_ext       = 1'b0;
        w_rel       = 1'b0;
        if (r_strobe) begin
            case (r_state)
                S_IDLE: begin
                    case (r_byte)
                        8'hE0: w_state_nxt = S_EXT;
                        8'hF0: w_state_nxt = S_BRK;
                        8'hE1: begin
                            w_state_nxt = S_PAUSE;
                            w_skip_nxt  = 3'd7;
                        end
                        8'h00, 8'hAA, 8'hFA, 8'hEE: ;
                        default: w_emit = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (r_byte == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (r_byte != 8'hE0) begin
                        w_emit      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_emit      = 1'b1;
                    w_rel       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_emit      = 1'b1;
                    w_ext       = 1'b1;
                    w_rel       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_PAUSE: begin
                    // Remaining Pause bytes are swallowed; leave once the last one is seen
                    w_skip_nxt = (r_skip == 3'd0) ? 3'd0 : r_skip - 3'd1;
                    if (r_skip <= 3'd1)
                        w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // US-layout table: unshifted / shifted character per Set-2 code
    always_comb begin
        w_base    = 8'h00;
        w_shifted = 8'h00;
        w_letter  = 1'b0;
        case (r_byte)
            8'h1C: begin w_base = 8'h61; w_letter = 1'b1; end
            8'h32: begin w_base = 8'h62; w_letter = 1'b1; end
            8'h21: begin w_base = 8'h63; w_letter = 1'b1; end
            8'h23: begin w_base = 8'h64; w_letter = 1'b1; end
            8'h24: begin w_base = 8'h65; w_letter = 1'b1; end
            8'h2B: begin w_base = 8'h66; w_letter = 1'b1; end
            8'h34: begin w_base = 8'h67; w_letter = 1'b1; end
            8'h33: begin w_base = 8'h68; w_letter = 1'b1; end
            8'h43: begin w_base = 8'h69; w_letter = 1'b1; end
            8'h3B: begin w_base = 8'h6A; w_letter = 1'b1; end
            8'h42: begin w_base = 8'h6B; w_letter = 1'b1; end
            8'h4B: begin w_base = 8'h6C; w_letter = 1'b1; end
            8'h3A: begin w_base = 8'h6D; w_letter = 1'b1; end
            8'h31: begin w_base = 8'h6E; w_letter = 1'b1; end
            8'h44: begin w_base = 8'h6F; w_letter = 1'b1; end
            8'h4D: begin w_base = 8'h70; w_letter = 1'b1; end
            8'h15: begin w_base = 8'h71; w_letter = 1'b1; end
            8'h2D: begin w_base = 8'h72; w_letter = 1'b1; end
            8'h1B: begin w_base = 8'h73; w_letter = 1'b1; end
            8'h2C: begin w_base = 8'h74; w_letter = 1'b1; end
            8'h3C: begin w_base = 8'h75; w_letter = 1'b1; end
            8'h2A: begin w_base = 8'h76; w_letter = 1'b1; end
            8'h1D: begin w_base = 8'h77; w_letter = 1'b1; end
            8'h22: begin w_base = 8'h78; w_letter = 1'b1; end
            8'h35: begin w_base = 8'h79; w_letter = 1'b1; end
            8'h1A: begin w_base = 8'h7A; w_letter = 1'b1; end
            8'h16: begin w_base = 8'h31; w_shifted = 8'h21; end
            8'h1E: begin w_base = 8'h32; w_shifted = 8'h40; end
            8'h26: begin w_base = 8'h33; w_shifted = 8'h23; end
            8'h25: begin w_base = 8'h34; w_shifted = 8'h24; end
            8'h2E: begin w_base = 8'h35; w_shifted = 8'h25; end
            8'h36: begin w_base = 8'h36; w_shifted = 8'h5E; end
            8'h3D: begin w_base = 8'h37; w_shifted = 8'h26; end
            8'h3E: begin w_base = 8'h38; w_shifted = 8'h2A; end
            8'h46: begin w_base = 8'h39; w_shifted = 8'h28; end
            8'h45: begin w_base = 8'h30; w_shifted = 8'h29; end
            8'h0E: begin w_base = 8'h60; w_shifted = 8'h7E; end
            8'h4E: begin w_base = 8'h2D; w_shifted = 8'h5F; end
            8'h55: begin w_base = 8'h3D; w_shifted = 8'h2B; end
            8'h54: begin w_base = 8'h5B; w_shifted = 8'h7B; end
            8'h5B: begin w_base = 8'h5D; w_shifted = 8'h7D; end
            8'h5D: begin w_base = 8'h5C; w_shifted = 8'h7C; end
            8'h4C: begin w_base = 8'h3B; w_shifted = 8'h3A; end
            8'h52: begin w_base = 8'h27; w_shifted = 8'h22; end
            8'h41: begin w_base = 8'h2C; w_shifted = 8'h3C; end
            8'h49: begin w_base = 8'h2E; w_shifted = 8'h3E; end
            8'h4A: begin w_base = 8'h2F; w_shifted = 8'h3F; end
            8'h29: begin w_base = 8'h20; w_shifted = 8'h20; end
            8'h5A: begin w_base = 8'h0D; w_shifted = 8'h0D; end
            8'h66: begin w_base = 8'h08; w_shifted = 8'h08; end
            8'h0D: begin w_base = 8'h09; w_shifted = 8'h09; end
            8'h76: begin w_base = 8'h1B; w_shifted = 8'h1B; end
            default: ;
        endcase
    end

    always_comb begin
        if (w_ext)
            w_ascii = 8'h00;
        else if (w_letter)
            w_ascii = (r_shift ^ r_caps) ? (w_base - 8'h20) : w_base;
        else
            w_ascii = r_shift ? w_shifted : w_base;
    end

    assign w_event = {w_ext, w_rel, r_byte, w_ascii};

    always_comb begin
        w_lshift_nxt = r_lshift;
        w_rshift_nxt = r_rshift;
        w_caps_nxt   = r_caps;
        if (w_emit && !w_ext) begin
            if (r_byte == 8'h12) w_lshift_nxt = ~w_rel;
            if (r_byte == 8'h59) w_rshift_nxt = ~w_rel;
            if (r_byte == 8'h58 && !w_rel) w_caps_nxt = ~r_caps;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_shift  <= 1'b0;
            r_caps   <= 1'b0;
        end else begin
            r_lshift <= w_lshift_nxt;
            r_rshift <= w_rshift_nxt;
            r_shift  <= w_lshift_nxt | w_rshift_nxt;
            r_caps   <= w_caps_nxt;
        end
    end

    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = key_rd & r_valid;
    assign w_push_ok   = w_emit & (~w_full | w_pop);
    assign w_ovf_set   = w_emit & w_full & ~w_pop;
    assign w_rd_nxt    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop)
            w_count_nxt = r_count + CNT_W'(1);
        else if (!w_push_ok && w_pop)
            w_count_nxt = r_count - CNT_W'(1);
    end

    always_comb begin
        if (w_count_nxt == CNT_W'(0))
            w_head_nxt = '0;
        else if (w_push_ok && r_wr_ptr == w_rd_nxt)
            w_head_nxt = w_event;
        else
            w_head_nxt = r_mem[w_rd_nxt];
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= w_event;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_valid    <= (w_count_nxt != CNT_W'(0));
            r_head     <= w_head_nxt;
            r_overflow <= w_ovf_set | (r_overflow & ~overflow_clr);
        end
    end

    assign key_valid    = r_valid;
    assign key_code     = r_head.code;
    assign key_ascii    = r_head.ascii;
    assign key_release  = r_head.rel;
    assign key_extended = r_head.ext;
    assign key_count    = r_count;
    assign overflow     = r_overflow;
    assign shift_state  = r_shift;
    assign caps_lock    = r_caps;

endmodule
